// File: rtl/led_shift_rx.sv
// led_shift_rx: receiver for the led_do/led_clk/led_clr/led_pen serial LED chain.
// Oversamples the pins in the clk domain, rebuilds each WIDTH-bit frame (MSB first)
// and presents it in parallel with a one-cycle valid strobe. Partial frames that
// stall are dropped after TIMEOUT cycles and flagged with frame_err.
//
// Output semantics: word_valid and frame_err are single-cycle strobes with no
// back-pressure (no ready). led_word changes only on the cycle word_valid is
// high and is stable otherwise. The two strobes are never high together.
module led_shift_rx #(
  parameter int WIDTH       = 16,
  parameter bit INVERT      = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int TO_W        = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       led_do,
  input  logic                       led_clk,
  input  logic                       led_clr,
  input  logic                       led_pen,
  output logic [WIDTH-1:0]           led_word,
  output logic                       word_valid,
  output logic                       frame_err,
  output logic                       busy,
  output logic                       dbg_state,
  output logic [$clog2(WIDTH)-1:0]   dbg_cnt
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Synchroniser chains; index SYNC_STAGES-1 is the synchronised pin value.
  logic [SYNC_STAGES-1:0] do_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic [SYNC_STAGES-1:0] pen_sync;

  logic do_s;
  logic clk_s;
  logic clr_s;
  logic pen_s;

  // One-cycle delayed copies: clk_s_d for edge detection, do_s_d for
  // setup-side sampling of the data pin.
  logic clk_s_d;
  logic do_s_d;

  logic rise;
  logic take;
  logic bit_in;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  assign do_s  = do_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign clr_s = clr_sync[SYNC_STAGES-1];
  assign pen_s = pen_sync[SYNC_STAGES-1];

  // Rising edge of the synchronised shift clock; output-enable low masks it.
  assign rise   = clk_s & ~clk_s_d;
  assign take   = rise & pen_s;
  // Data from the cycle before the edge, so a transmitter that updates led_do
  // on the same edge as led_clk still delivers the intended bit.
  assign bit_in = do_s_d ^ INVERT;

  // Pin synchronisers and the delayed copies used for edge and data sampling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      do_sync  <= '0;
      clk_sync <= '0;
      clr_sync <= '0;
      pen_sync <= '0;
      clk_s_d  <= 1'b0;
      do_s_d   <= 1'b0;
    end else begin
      do_sync  <= {do_sync[SYNC_STAGES-2:0], led_do};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], led_clk};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], led_clr};
      pen_sync <= {pen_sync[SYNC_STAGES-2:0], led_pen};
      clk_s_d  <= clk_s;
      do_s_d   <= do_s;
    end
  end

  // Frame state register, shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. Priority: chain clear, then an accepted bit, then timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    sr_d    = sr_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (!clr_s) begin
      // Chain clear wipes the partial frame but keeps the last good word.
      state_d = IDLE;
      cnt_d   = '0;
      to_d    = '0;
      sr_d    = '0;
    end else if (take) begin
      sr_d = {sr_q[WIDTH-2:0], bit_in};
      to_d = '0;
      case (state_q)
        IDLE: begin
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end
        RECV: begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Final bit: publish the frame; the next bit starts a new one.
            word_d  = {sr_q[WIDTH-2:0], bit_in};
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end else if (state_q == RECV) begin
      if (to_q == TO_W'(TIMEOUT - 1)) begin
        // Stalled mid-frame: drop the partial frame.
        err_d   = 1'b1;
        sr_d    = '0;
        cnt_d   = '0;
        to_d    = '0;
        state_d = IDLE;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  assign led_word   = word_q;
  assign word_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == RECV);
  assign dbg_state  = state_q;
  assign dbg_cnt    = cnt_q;

endmodule

// File: tb/tb_led_shift_rx.sv
// Bench for led_shift_rx: drives the serial pins like the LED transmitter and
// checks rebuilt words through an expected-word queue.
module tb_led_shift_rx;

  logic        clk;
  logic        reset;
  logic        led_do;
  logic        led_clk;
  logic        led_clr;
  logic        led_pen;
  logic [15:0] led_word;
  logic        word_valid;
  logic        frame_err;
  logic        busy;
  logic        dbg_state;
  logic [3:0]  dbg_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cnt    = 0;
  int err_cnt      = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] exp_w;
  logic [15:0] exp_q[$];

  led_shift_rx dut (
    .clk        (clk),
    .reset      (reset),
    .led_do     (led_do),
    .led_clk    (led_clk),
    .led_clr    (led_clr),
    .led_pen    (led_pen),
    .led_word   (led_word),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_cnt    (dbg_cnt)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the top n bits of 'bits', MSB first; data set up in the low phase.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      led_do  = ~bits[31-i];
      led_clk = 1'b0;
      wait_cyc(4);
      led_clk = 1'b1;
      wait_cyc(4);
    end
    led_clk = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits({w, 16'h0000}, 16);
  endtask

  // Transmitter that moves led_do to the next bit on the very edge led_clk rises.
  task automatic send_same_edge(input logic [31:0] bits, input int n);
    led_do  = ~bits[31];
    led_clk = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < n; i++) begin
      led_clk = 1'b1;
      if (i < n - 1) led_do = ~bits[30-i];
      wait_cyc(4);
      led_clk = 1'b0;
      wait_cyc(4);
    end
  endtask

  // Scoreboard monitor: every word_valid pops one expected word.
  always @(negedge clk) begin
    if (reset) begin
      if (word_valid) begin
        valid_cnt++;
        check("strobe_exclusive", {31'b0, frame_err}, 32'h0);
        check("valid_one_cycle", {31'b0, prev_valid}, 32'h0);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_word: got %0h, expected no word", led_word);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {16'h0, led_word}, {16'h0, exp_w});
        end
      end
      if (frame_err) err_cnt++;
      prev_valid = word_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  int          v_before;
  logic        busy_or;
  logic [15:0] rnd_w;

  initial begin
    reset   = 1'b0;
    led_do  = 1'b1;
    led_clk = 1'b0;
    led_clr = 1'b1;
    led_pen = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check("rst_word", {16'h0, led_word}, 32'h0);
    check("rst_valid", {31'b0, word_valid}, 32'h0);
    check("rst_err", {31'b0, frame_err}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b1;
    wait_cyc(6);

    // Basic frame.
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3);
    wait_cyc(6);
    check("busy_after_frame", {31'b0, busy}, 32'h0);

    // Data changing on the same edge as led_clk, two frames back to back.
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    send_same_edge({16'hFFFF, 16'h0000}, 32);
    wait_cyc(6);

    // Stall after 7 bits: partial frame dropped by timeout.
    send_bits(32'h0F0F_0000, 7);
    check("busy_partial", {31'b0, busy}, 32'h1);
    check("cnt_partial", {28'h0, dbg_cnt}, 32'd7);
    wait_cyc(1100);
    check("timeout_err_cnt", err_cnt, 1);
    check("busy_after_timeout", {31'b0, busy}, 32'h0);
    check("word_kept_timeout", {16'h0, led_word}, 32'h0000);
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    wait_cyc(6);

    // Chain clear mid-frame.
    send_bits(32'h5555_0000, 9);
    check("busy_before_clr", {31'b0, busy}, 32'h1);
    v_before = valid_cnt;
    led_clr = 1'b0;
    wait_cyc(10);
    check("busy_during_clr", {31'b0, busy}, 32'h0);
    check("word_held_clr", {16'h0, led_word}, 32'h1234);
    led_clr = 1'b1;
    wait_cyc(4);
    check("no_valid_clr", valid_cnt - v_before, 0);
    exp_q.push_back(16'h8001);
    send_word(16'h8001);
    wait_cyc(6);
    check("err_after_clr", err_cnt, 1);

    // Output enable low: clock pulses ignored.
    v_before = valid_cnt;
    busy_or  = 1'b0;
    led_pen  = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 16; i++) begin
      led_do  = ($urandom_range(0, 1) == 1);
      led_clk = 1'b0;
      wait_cyc(4);
      busy_or = busy_or | busy;
      led_clk = 1'b1;
      wait_cyc(4);
      busy_or = busy_or | busy;
    end
    led_clk = 1'b0;
    wait_cyc(4);
    led_pen = 1'b1;
    wait_cyc(4);
    check("pen_no_valid", valid_cnt - v_before, 0);
    check("pen_busy_never", {31'b0, busy_or}, 32'h0);

    // 20 bits: one word, then 4 bits of a new frame.
    exp_q.push_back(16'hBEEF);
    send_bits(32'hBEEF_A000, 20);
    wait_cyc(6);
    check("busy_overrun", {31'b0, busy}, 32'h1);
    check("cnt_overrun", {28'h0, dbg_cnt}, 32'd4);
    check("word_overrun", {16'h0, led_word}, 32'hBEEF);

    // Reset mid-frame.
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_word", {16'h0, led_word}, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_valid", {31'b0, word_valid}, 32'h0);
    check("rst_mid_err", {31'b0, frame_err}, 32'h0);
    check("rst_mid_cnt", {28'h0, dbg_cnt}, 32'h0);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(6);

    // Random frames.
    for (int i = 0; i < 3; i++) begin
      rnd_w = 16'($urandom_range(0, 16'hFFFF));
      exp_q.push_back(rnd_w);
      send_word(rnd_w);
    end
    wait_cyc(12);

    check("exp_q_drained", exp_q.size(), 0);
    check("total_valid", valid_cnt, 9);
    check("total_err", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
